uncache_access_arbiter: RTL and testbench
=========================================

Name: uncache_access_arbiter

Overview:
- Shares the single uncached bus port between the instruction-fetch side (I) and the data side (D).
- Requests arrive here only after the MMU has flagged them uncached (kseg1, 0xA000_0000–0xBFFF_FFFF).
- Allows one outstanding transaction at a time, arbitrates round-robin, translates kseg0/kseg1 virtual addresses to physical, and returns a registered response to the granted side.

Parameters:
- DATA_WIDTH, 32, width of read/write data.
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-high reset.
- i_req_valid  in  1  I-side request (read only).
- i_req_addr  in  32  I-side virtual address.
- i_req_ready  out  1  I-side request accepted (1-cycle pulse).
- i_resp_valid  out  1  I-side response pulse.
- i_resp_rdata  out  DATA_WIDTH  I-side read data.
- d_req_valid  in  1  D-side request.
- d_req_addr  in  32  D-side virtual address.
- d_req_wr  in  1  1 = write, 0 = read.
- d_req_size  in  2  0 = byte, 1 = half, 2 = word.
- d_req_wdata  in  DATA_WIDTH  write data.
- d_req_wstrb  in  STRB_WIDTH  byte strobes.
- d_req_ready  out  1  D-side request accepted (1-cycle pulse).
- d_resp_valid  out  1  D-side response pulse (for both reads and writes).
- d_resp_rdata  out  DATA_WIDTH  D-side read data.
- bus_req_valid  out  1  uncached bus request.
- bus_req_ready  in  1  bus accepts the request.
- bus_req_addr  out  32  physical address.
- bus_req_wr / bus_req_size / bus_req_wdata / bus_req_wstrb  out  1/2/DATA_WIDTH/STRB_WIDTH  latched request fields.
- bus_resp_valid  in  1  bus response (read data or write acknowledge).
- bus_resp_rdata  in  DATA_WIDTH  bus read data.
- busy  out  1  high while state != IDLE.

Behaviour:
- Reset values: state = IDLE, last_grant = I. All ready, valid and busy outputs are 0. All latched fields and rdata registers are 0.
- An assertion of rst at any point, including mid-transaction, returns to IDLE immediately. The outstanding transaction is abandoned and no response pulse is issued.
- State IDLE:
  - Only one valid → grant it.
  - Both valid → grant the side not equal to last_grant. The first tie after reset therefore goes to D.
  - On grant (same cycle): pulse the granted *_req_ready, latch the request fields, update last_grant, go to REQ.
  - An I grant latches wr = 0, size = 2, wstrb = 0, wdata = 0.
- State REQ:
  - bus_req_valid = 1 and all bus_req_* fields are held stable.
  - bus_req_valid stays high until bus_req_ready is sampled high; then go to RESP.
- State RESP:
  - bus_req_valid = 0.
  - On bus_resp_valid: capture bus_resp_rdata into the granted side's rdata register (write responses capture too; the value is don't-care). Go to IDLE.
  - Next cycle: the granted *_resp_valid pulses high for exactly 1 cycle. Responses have no backpressure.
  - A new grant may occur in the same cycle as that response pulse.
- *_resp_rdata holds its value until the next response to the same side.
- Address translation, applied to the latched address:
  - addr[31:29] = 3'b100 or 3'b101 → {3'b000, addr[28:0]}.
  - All other addresses pass through unchanged.
- Minimum latency: request grant at cycle 0 → bus_req_valid at cycle 1 → (bus_req_ready at cycle 1, bus_resp_valid at cycle 2) → resp_valid at cycle 3.
- bus_resp_valid arriving outside RESP is ignored.
- *_req_valid arriving while not in IDLE is not accepted (ready stays 0). The requester holds valid until ready.

Test Plan:
- Reset, then I read at 0xBFC0_0000; bus ready immediately; response data 0x1234_5678 → bus_req_addr = 0x1FC0_0000, wr = 0, size = 2; i_resp_valid pulses at cycle 3 with rdata 0x1234_5678; d_resp_valid stays 0.
- D write, addr 0xBFAF_F000, wdata 0xDEAD_BEEF, wstrb 0xF; bus_req_ready delayed 3 cycles → bus_req_valid held 4 cycles with fields stable and addr 0x1FAF_F000; d_resp_valid pulses once after bus_resp_valid.
- I and D both valid continuously for 4 transactions after reset → grant order D, I, D, I; exactly one bus_req outstanding at a time.
- Address 0x8000_0010 → 0x0000_0010; address 0x1FC0_0004 → unchanged.
- rst asserted while in RESP with bus_resp_valid pending → busy = 0, no resp_valid pulse; the next request is granted normally.
- D request arriving while I transaction in REQ → d_req_ready stays 0 until the cycle after the I response is captured; no spurious bus_resp_valid is accepted in IDLE.

Source files
------------

// File: rtl/uncache_access_arbiter.sv
// Round-robin arbiter sharing the uncached bus port between I and D sides.
// One transaction in flight; kseg0/kseg1 addresses are mapped to physical.
module uncache_access_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    input  logic [31:0]           i_req_addr,
    output logic                  i_req_ready,
    output logic                  i_resp_valid,
    output logic [DATA_WIDTH-1:0] i_resp_rdata,
    input  logic                  d_req_valid,
    input  logic [31:0]           d_req_addr,
    input  logic                  d_req_wr,
    input  logic [1:0]            d_req_size,
    input  logic [DATA_WIDTH-1:0] d_req_wdata,
    input  logic [STRB_WIDTH-1:0] d_req_wstrb,
    output logic                  d_req_ready,
    output logic                  d_resp_valid,
    output logic [DATA_WIDTH-1:0] d_resp_rdata,
    output logic                  bus_req_valid,
    input  logic                  bus_req_ready,
    output logic [31:0]           bus_req_addr,
    output logic                  bus_req_wr,
    output logic [1:0]            bus_req_size,
    output logic [DATA_WIDTH-1:0] bus_req_wdata,
    output logic [STRB_WIDTH-1:0] bus_req_wstrb,
    input  logic                  bus_resp_valid,
    input  logic [DATA_WIDTH-1:0] bus_resp_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_last_d;
    logic                  r_sel_d;
    logic [31:0]           r_addr;
    logic                  r_wr;
    logic [1:0]            r_size;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic [DATA_WIDTH-1:0] r_i_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;
    logic                  r_i_resp;
    logic                  r_d_resp;
    logic                  w_grant_i;
    logic                  w_grant_d;
    logic                  w_capture;
    logic                  w_kseg01;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_capture   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // On a tie the side that did not win last time goes first
                if (i_req_valid && d_req_valid) begin
                    w_grant_d = ~r_last_d;
                    w_grant_i = r_last_d;
                end else begin
                    w_grant_i = i_req_valid;
                    w_grant_d = d_req_valid;
                end
                if (i_req_valid || d_req_valid) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_req_ready) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (bus_resp_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_d <= 1'b0;
            r_sel_d  <= 1'b0;
            r_addr   <= '0;
            r_wr     <= 1'b0;
            r_size   <= 2'd0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else if (w_grant_d) begin
            r_last_d <= 1'b1;
            r_sel_d  <= 1'b1;
            r_addr   <= d_req_addr;
            r_wr     <= d_req_wr;
            r_size   <= d_req_size;
            r_wdata  <= d_req_wdata;
            r_wstrb  <= d_req_wstrb;
        end else if (w_grant_i) begin
            r_last_d <= 1'b0;
            r_sel_d  <= 1'b0;
            r_addr   <= i_req_addr;
            r_wr     <= 1'b0;
            r_size   <= 2'd2;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_resp  <= 1'b0;
            r_d_resp  <= 1'b0;
        end else begin
            r_i_resp <= w_capture & ~r_sel_d;
            r_d_resp <= w_capture & r_sel_d;
            if (w_capture && !r_sel_d) begin
                r_i_rdata <= bus_resp_rdata;
            end
            if (w_capture && r_sel_d) begin
                r_d_rdata <= bus_resp_rdata;
            end
        end
    end

    assign w_kseg01 = (r_addr[31:29] == 3'b100) ||
                      (r_addr[31:29] == 3'b101);

    assign i_req_ready   = w_grant_i & ~rst;
    assign d_req_ready   = w_grant_d & ~rst;
    assign i_resp_valid  = r_i_resp;
    assign d_resp_valid  = r_d_resp;
    assign i_resp_rdata  = r_i_rdata;
    assign d_resp_rdata  = r_d_rdata;
    assign bus_req_valid = (r_state == S_REQ);
    assign bus_req_addr  = w_kseg01 ? {3'b000, r_addr[28:0]} : r_addr;
    assign bus_req_wr    = r_wr;
    assign bus_req_size  = r_size;
    assign bus_req_wdata = r_wdata;
    assign bus_req_wstrb = r_wstrb;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_uncache_access_arbiter.sv
// Bench for uncache_access_arbiter: directed scenarios plus random
// transactions checked against a transaction-level reference model.
module tb_uncache_access_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic        i_req_ready;
    logic        i_resp_valid;
    logic [31:0] i_resp_rdata;
    logic        d_req_valid;
    logic [31:0] d_req_addr;
    logic        d_req_wr;
    logic [1:0]  d_req_size;
    logic [31:0] d_req_wdata;
    logic [3:0]  d_req_wstrb;
    logic        d_req_ready;
    logic        d_resp_valid;
    logic [31:0] d_resp_rdata;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_req_addr;
    logic        bus_req_wr;
    logic [1:0]  bus_req_size;
    logic [31:0] bus_req_wdata;
    logic [3:0]  bus_req_wstrb;
    logic        bus_resp_valid;
    logic [31:0] bus_resp_rdata;
    logic        busy;

    int errors = 0;
    int checks = 0;

    bit          m_last;
    logic [31:0] m_rd [2];

    uncache_access_arbiter dut (
        .clk(clk),
        .rst(rst),
        .i_req_valid(i_req_valid),
        .i_req_addr(i_req_addr),
        .i_req_ready(i_req_ready),
        .i_resp_valid(i_resp_valid),
        .i_resp_rdata(i_resp_rdata),
        .d_req_valid(d_req_valid),
        .d_req_addr(d_req_addr),
        .d_req_wr(d_req_wr),
        .d_req_size(d_req_size),
        .d_req_wdata(d_req_wdata),
        .d_req_wstrb(d_req_wstrb),
        .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid),
        .d_resp_rdata(d_resp_rdata),
        .bus_req_valid(bus_req_valid),
        .bus_req_ready(bus_req_ready),
        .bus_req_addr(bus_req_addr),
        .bus_req_wr(bus_req_wr),
        .bus_req_size(bus_req_size),
        .bus_req_wdata(bus_req_wdata),
        .bus_req_wstrb(bus_req_wstrb),
        .bus_resp_valid(bus_resp_valid),
        .bus_resp_rdata(bus_resp_rdata),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] xlate(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a < 32'hA000_0000) return a - 32'h8000_0000;
        if (a >= 32'hA000_0000 && a < 32'hC000_0000) return a - 32'hA000_0000;
        return a;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 2))
            0:       return 32'h8000_0000 + {3'b000, r[28:0]};
            1:       return 32'hA000_0000 + {3'b000, r[28:0]};
            default: return r;
        endcase
    endfunction

    task automatic idle_inputs();
        i_req_valid    = 1'b0;
        i_req_addr     = '0;
        d_req_valid    = 1'b0;
        d_req_addr     = '0;
        d_req_wr       = 1'b0;
        d_req_size     = 2'd0;
        d_req_wdata    = '0;
        d_req_wstrb    = '0;
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        bus_resp_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        samp();
        chk("rst_i_ready", i_req_ready, 0);
        chk("rst_d_ready", d_req_ready, 0);
        chk("rst_i_resp", i_resp_valid, 0);
        chk("rst_d_resp", d_resp_valid, 0);
        chk("rst_bvalid", bus_req_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_i_rdata", i_resp_rdata, 0);
        chk("rst_d_rdata", d_resp_rdata, 0);
        chk("rst_baddr", bus_req_addr, 0);
        chk("rst_bwdata", bus_req_wdata, 0);
        chk("rst_bfields", {bus_req_wr, bus_req_size, bus_req_wstrb}, 0);
        tick();
        rst = 1'b0;
        m_last = 1'b0;
        m_rd[0] = '0;
        m_rd[1] = '0;
        tick();
    endtask

    task automatic run_txn(input bit vi, input bit vd,
                           input logic [31:0] ia, input logic [31:0] da,
                           input bit wr, input logic [1:0] sz,
                           input logic [31:0] wd, input logic [3:0] ws,
                           input int rdly, input int pdly,
                           input logic [31:0] rd);
        bit          w;
        logic [31:0] ea;
        logic [31:0] ewd;
        logic [3:0]  ews;
        bit          ewr;
        logic [1:0]  esz;
        if (vi && vd) w = (m_last == 1'b0);
        else w = vd;
        if (w) begin
            ea = xlate(da); ewr = wr; esz = sz; ewd = wd; ews = ws;
        end else begin
            ea = xlate(ia); ewr = 1'b0; esz = 2'd2; ewd = '0; ews = '0;
        end
        i_req_valid = vi;
        i_req_addr  = ia;
        d_req_valid = vd;
        d_req_addr  = da;
        d_req_wr    = wr;
        d_req_size  = sz;
        d_req_wdata = wd;
        d_req_wstrb = ws;
        samp();
        chk("grant_i", i_req_ready, !w);
        chk("grant_d", d_req_ready, w);
        tick();
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        i_req_addr  = $urandom;
        d_req_addr  = $urandom;
        d_req_wdata = $urandom;
        d_req_wstrb = 4'($urandom);
        d_req_wr    = ~wr;
        for (int k = 0; k <= rdly; k++) begin
            bus_req_ready  = (k == rdly);
            bus_resp_valid = 1'($urandom_range(0, 1));
            bus_resp_rdata = $urandom;
            samp();
            chk("req_bvalid", bus_req_valid, 1);
            chk("req_addr", bus_req_addr, ea);
            chk("req_wr", bus_req_wr, ewr);
            chk("req_size", bus_req_size, esz);
            chk("req_wdata", bus_req_wdata, ewd);
            chk("req_wstrb", bus_req_wstrb, ews);
            chk("req_busy", busy, 1);
            tick();
        end
        bus_req_ready = 1'b0;
        for (int k = 0; k <= pdly; k++) begin
            bus_resp_valid = (k == pdly);
            bus_resp_rdata = (k == pdly) ? rd : $urandom;
            samp();
            chk("resp_bvalid", bus_req_valid, 0);
            chk("early_resp", {i_resp_valid, d_resp_valid}, 0);
            tick();
        end
        bus_resp_valid = 1'b0;
        bus_resp_rdata = $urandom;
        m_rd[w] = rd;
        m_last = w;
        samp();
        chk("pulse_i", i_resp_valid, !w);
        chk("pulse_d", d_resp_valid, w);
        chk("rdata_i", i_resp_rdata, m_rd[0]);
        chk("rdata_d", d_resp_rdata, m_rd[1]);
        chk("done_busy", busy, 0);
        tick();
        samp();
        chk("one_pulse", {i_resp_valid, d_resp_valid}, 0);
        tick();
    endtask

    initial begin
        int  ng;
        int  nr;
        int  cyc;
        bit  outst;
        bit  gq [$];
        bit  vi;
        bit  vd;

        rst = 1'b1;
        idle_inputs();
        tick();
        do_reset();

        run_txn(1, 0, 32'hBFC0_0000, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678);
        run_txn(0, 1, 0, 32'hBFAF_F000, 1, 2'd2, 32'hDEAD_BEEF, 4'hF,
                3, 1, 32'h0BAD_F00D);
        run_txn(1, 0, 32'h8000_0010, 0, 0, 0, 0, 0, 1, 2, 32'hCAFE_0001);
        run_txn(0, 1, 0, 32'h1FC0_0004, 0, 2'd1, 32'h0000_5A5A, 4'h3,
                0, 0, 32'hCAFE_0002);

        // Both sides requesting continuously
        do_reset();
        i_req_valid    = 1'b1;
        i_req_addr     = 32'hA000_1000;
        d_req_valid    = 1'b1;
        d_req_addr     = 32'hA000_2000;
        bus_req_ready  = 1'b1;
        bus_resp_valid = 1'b1;
        bus_resp_rdata = 32'h7777_8888;
        ng = 0; nr = 0; cyc = 0; outst = 1'b0;
        while (nr < 4 && cyc < 60) begin
            samp();
            if (i_req_ready || d_req_ready) begin
                chk("rr_onehot", {i_req_ready, d_req_ready} == 2'b11, 0);
                gq.push_back(d_req_ready);
                ng++;
            end
            if (bus_req_valid && bus_req_ready) begin
                chk("rr_outst", outst, 0);
                outst = 1'b1;
            end
            if (i_resp_valid || d_resp_valid) begin
                outst = 1'b0;
                nr++;
            end
            tick();
            if (ng >= 4) begin
                i_req_valid = 1'b0;
                d_req_valid = 1'b0;
            end
            cyc++;
        end
        chk("rr_resps", nr, 4);
        chk("rr_grants", ng, 4);
        if (gq.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("rr_order", gq[k], (k % 2 == 0));
        end
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        m_last  = 1'b0;
        m_rd[0] = 32'h7777_8888;
        m_rd[1] = 32'h7777_8888;
        tick();
        run_txn(1, 1, 32'h9000_0100, 32'hA000_0200, 0, 2'd2, 0, 0,
                0, 0, 32'h1357_9BDF);

        // Reset in RESP with a response pending
        do_reset();
        i_req_valid = 1'b1;
        i_req_addr  = 32'hBFC0_0100;
        samp();
        chk("mr_grant", i_req_ready, 1);
        tick();
        i_req_valid   = 1'b0;
        bus_req_ready = 1'b1;
        samp();
        chk("mr_bvalid", bus_req_valid, 1);
        tick();
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b1;
        bus_resp_rdata = 32'hAAAA_5555;
        rst = 1'b1;
        samp();
        chk("mr_busy", busy, 0);
        chk("mr_nopulse0", {i_resp_valid, d_resp_valid}, 0);
        tick();
        rst = 1'b0;
        bus_resp_valid = 1'b0;
        samp();
        chk("mr_nopulse1", {i_resp_valid, d_resp_valid}, 0);
        chk("mr_rdata", i_resp_rdata, 0);
        m_last  = 1'b0;
        m_rd[0] = '0;
        m_rd[1] = '0;
        tick();
        run_txn(1, 1, 32'hA123_4560, 32'h8765_4320, 1, 2'd0, 32'h0000_00AB,
                4'h1, 1, 0, 32'h2468_ACE0);

        // D arrives while I is in flight
        do_reset();
        i_req_valid = 1'b1;
        i_req_addr  = 32'hA000_0040;
        samp();
        chk("dw_grant_i", i_req_ready, 1);
        tick();
        i_req_valid = 1'b0;
        d_req_valid = 1'b1;
        d_req_addr  = 32'hB000_0008;
        d_req_size  = 2'd2;
        for (int k = 0; k <= 2; k++) begin
            bus_req_ready = (k == 2);
            samp();
            chk("dw_noready_req", d_req_ready, 0);
            chk("dw_addr_i", bus_req_addr, xlate(32'hA000_0040));
            tick();
        end
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b1;
        bus_resp_rdata = 32'h1111_2222;
        samp();
        chk("dw_noready_resp", d_req_ready, 0);
        tick();
        bus_resp_rdata = 32'h3333_4444;
        samp();
        chk("dw_pulse_i", i_resp_valid, 1);
        chk("dw_rdata_i", i_resp_rdata, 32'h1111_2222);
        chk("dw_grant_d", d_req_ready, 1);
        tick();
        d_req_valid   = 1'b0;
        bus_req_ready = 1'b1;
        samp();
        chk("dw_addr_d", bus_req_addr, xlate(32'hB000_0008));
        tick();
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        samp();
        chk("dw_still_busy", busy, 1);
        chk("dw_no_d_pulse", d_resp_valid, 0);
        tick();
        bus_resp_valid = 1'b1;
        bus_resp_rdata = 32'h5555_6666;
        samp();
        tick();
        bus_resp_valid = 1'b0;
        samp();
        chk("dw_pulse_d", d_resp_valid, 1);
        chk("dw_rdata_d", d_resp_rdata, 32'h5555_6666);
        chk("dw_rdata_i_hold", i_resp_rdata, 32'h1111_2222);
        m_last  = 1'b1;
        m_rd[0] = 32'h1111_2222;
        m_rd[1] = 32'h5555_6666;
        tick();

        for (int n = 0; n < 24; n++) begin
            vi = 1'($urandom_range(0, 1));
            vd = 1'($urandom_range(0, 1));
            if (!vi && !vd) vi = 1'b1;
            run_txn(vi, vd, rand_addr(), rand_addr(),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                    $urandom, 4'($urandom), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
